// File: rtl/cp0_unit.sv
// MIPS-style coprocessor 0: SR, Cause, EPC and PRId, with exception commit and eret.
// Define CP0_BADVADDR_EN to add the read-only BadVAddr register (reg 8).
module cp0_unit (
   input  logic        clk,
   input  logic        reset,
   input  logic [4:0]  A1,
   input  logic [4:0]  A2,
   input  logic [31:0] DIn,
   input  logic        WE,
   input  logic        EXLClr,
   input  logic        Exception,
   input  logic [4:0]  ExcCode,
   input  logic [31:0] PC,
   input  logic        BD,
   input  logic [5:0]  HWInt,
   input  logic [31:0] BadAddr,
   output logic [31:0] DOut,
   output logic [31:0] EPC,
   output logic        exl,
   output logic        ie,
   output logic [5:0]  im
);

   localparam logic [4:0]  REG_BADVADDR = 5'd8;
   localparam logic [4:0]  REG_SR       = 5'd12;
   localparam logic [4:0]  REG_CAUSE    = 5'd13;
   localparam logic [4:0]  REG_EPC      = 5'd14;
   localparam logic [4:0]  REG_PRID     = 5'd15;
   localparam logic [31:0] PRID_VALUE   = 32'h2017_1226;

   logic [5:0]  im_q;
   logic        exl_q;
   logic        ie_q;
   logic        bd_q;
   logic [5:0]  ip_q;
   logic [4:0]  exc_code_q;
   logic [31:2] epc_q;
   logic [31:0] pc_adj;
   logic [31:0] badvaddr_val;

   // A delay-slot instruction restarts from its branch, one word earlier.
   assign pc_adj = BD ? (PC - 32'd4) : PC;

   always_ff @(posedge clk) begin
      if (reset) begin
         im_q       <= '0;
         exl_q      <= 1'b0;
         ie_q       <= 1'b0;
         bd_q       <= 1'b0;
         ip_q       <= '0;
         exc_code_q <= '0;
         epc_q      <= '0;
      end else begin
         ip_q <= HWInt;
         if (Exception) begin
            exl_q      <= 1'b1;
            exc_code_q <= ExcCode;
            bd_q       <= BD;
            epc_q      <= pc_adj[31:2];
         end else begin
            if (WE && (A2 == REG_SR)) begin
               im_q  <= DIn[15:10];
               exl_q <= DIn[1];
               ie_q  <= DIn[0];
            end
            if (WE && (A2 == REG_EPC)) begin
               epc_q <= DIn[31:2];
            end
            // eret wins over a simultaneous SR write of the exl bit.
            if (EXLClr) begin
               exl_q <= 1'b0;
            end
         end
      end
   end

`ifdef CP0_BADVADDR_EN
   logic [31:0] badvaddr_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         badvaddr_q <= '0;
      end else if (Exception && ((ExcCode == 5'd4) || (ExcCode == 5'd5))) begin
         badvaddr_q <= BadAddr;
      end
   end

   assign badvaddr_val = badvaddr_q;
`else
   assign badvaddr_val = 32'd0;
`endif

   always_comb begin
      DOut = 32'd0;
      case (A1)
         REG_BADVADDR: DOut = badvaddr_val;
         REG_SR:       DOut = {16'd0, im_q, 8'd0, exl_q, ie_q};
         REG_CAUSE:    DOut = {bd_q, 15'd0, ip_q, 3'd0, exc_code_q, 2'b00};
         REG_EPC:      DOut = {epc_q, 2'b00};
         REG_PRID:     DOut = PRID_VALUE;
         default:      DOut = 32'd0;
      endcase
   end

   assign EPC = {epc_q, 2'b00};
   assign exl = exl_q;
   assign ie  = ie_q;
   assign im  = im_q;

   logic unused_bits;
   assign unused_bits = ^{pc_adj[1:0], DIn[1:0], BadAddr};

endmodule

// File: tb/tb_cp0_unit.sv
// Directed table-driven bench for cp0_unit; reg 8 expectations follow CP0_BADVADDR_EN.
module tb_cp0_unit;

   logic        clk;
   logic        reset;
   logic [4:0]  A1;
   logic [4:0]  A2;
   logic [31:0] DIn;
   logic        WE;
   logic        EXLClr;
   logic        Exception;
   logic [4:0]  ExcCode;
   logic [31:0] PC;
   logic        BD;
   logic [5:0]  HWInt;
   logic [31:0] BadAddr;
   logic [31:0] DOut;
   logic [31:0] EPC;
   logic        exl;
   logic        ie;
   logic [5:0]  im;

   int tests = 0;
   int fails = 0;

   cp0_unit dut (
      .clk(clk), .reset(reset), .A1(A1), .A2(A2), .DIn(DIn), .WE(WE),
      .EXLClr(EXLClr), .Exception(Exception), .ExcCode(ExcCode), .PC(PC),
      .BD(BD), .HWInt(HWInt), .BadAddr(BadAddr), .DOut(DOut), .EPC(EPC),
      .exl(exl), .ie(ie), .im(im)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        rst;
      logic        we;
      logic [4:0]  a2;
      logic [31:0] din;
      logic        clr;
      logic        exc;
      logic [4:0]  code;
      logic [31:0] pc;
      logic        bd;
      logic [5:0]  hw;
      logic [31:0] bad;
      logic [4:0]  rd;
      logic [31:0] e_dout;
      logic        e_exl;
      logic        e_ie;
      logic [5:0]  e_im;
      logic [31:0] e_epc;
   } vec_t;

   localparam int NV = 23;
   vec_t vecs [NV];

   function automatic vec_t mk(
      input logic rst, input logic we, input logic [4:0] a2, input logic [31:0] din,
      input logic clr, input logic exc, input logic [4:0] code, input logic [31:0] pc,
      input logic bd, input logic [5:0] hw, input logic [31:0] bad, input logic [4:0] rd,
      input logic [31:0] e_dout, input logic e_exl, input logic e_ie, input logic [5:0] e_im,
      input logic [31:0] e_epc);
      vec_t v;
      v.rst = rst; v.we = we; v.a2 = a2; v.din = din; v.clr = clr; v.exc = exc;
      v.code = code; v.pc = pc; v.bd = bd; v.hw = hw; v.bad = bad; v.rd = rd;
      v.e_dout = e_dout; v.e_exl = e_exl; v.e_ie = e_ie; v.e_im = e_im; v.e_epc = e_epc;
      return v;
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   logic [31:0] bv_a;
   logic [31:0] bv_b;

   initial begin
`ifdef CP0_BADVADDR_EN
      bv_a = 32'h1234_5679;
      bv_b = 32'h0000_7F0D;
`else
      bv_a = 32'd0;
      bv_b = 32'd0;
`endif
      //            rst we a2  din           clr exc code pc            bd hw      bad           rd   dout           exl ie im     epc
      vecs[0]  = mk(1, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0,         0, 0, 6'h00, 32'h0);
      vecs[1]  = mk(1, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        15, 32'h2017_1226, 0, 0, 6'h00, 32'h0);
      vecs[2]  = mk(0, 1, 12, 32'h0000_0C01, 0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0000_0C01, 0, 1, 6'h03, 32'h0);
      vecs[3]  = mk(0, 0, 0,  32'h0,        0, 1, 12, 32'h0000_3010, 0, 6'h00, 32'h0,        13, 32'h0000_0030, 1, 1, 6'h03, 32'h0000_3010);
      vecs[4]  = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        14, 32'h0000_3010, 1, 1, 6'h03, 32'h0000_3010);
      vecs[5]  = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0000_0C03, 1, 1, 6'h03, 32'h0000_3010);
      vecs[6]  = mk(0, 0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0000_0C01, 0, 1, 6'h03, 32'h0000_3010);
      vecs[7]  = mk(0, 0, 0,  32'h0,        0, 1, 10, 32'h0000_3024, 1, 6'h00, 32'h0,        13, 32'h8000_0028, 1, 1, 6'h03, 32'h0000_3020);
      vecs[8]  = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        14, 32'h0000_3020, 1, 1, 6'h03, 32'h0000_3020);
      vecs[9]  = mk(0, 0, 0,  32'h0,        1, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0000_0C01, 0, 1, 6'h03, 32'h0000_3020);
      vecs[10] = mk(0, 1, 14, 32'hFFFF_FFFF, 1, 1, 5,  32'h0000_4000, 0, 6'h00, 32'h1234_5679, 14, 32'h0000_4000, 1, 1, 6'h03, 32'h0000_4000);
      vecs[11] = mk(0, 1, 14, 32'hFFFF_FFFF, 0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        14, 32'hFFFF_FFFC, 1, 1, 6'h03, 32'hFFFF_FFFC);
      vecs[12] = mk(0, 1, 12, 32'h0000_FC03, 1, 0, 0,  32'h0,        0, 6'h00, 32'h0,        12, 32'h0000_FC01, 0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[13] = mk(0, 1, 13, 32'hFFFF_FFFF, 0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        13, 32'h0000_0014, 0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[14] = mk(0, 1, 15, 32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        15, 32'h2017_1226, 0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[15] = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h02, 32'h0,        13, 32'h0000_0814, 0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[16] = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        13, 32'h0000_0014, 0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[17] = mk(0, 1, 3,  32'hFFFF_FFFF, 0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        8,  bv_a,          0, 1, 6'h3F, 32'hFFFF_FFFC);
      vecs[18] = mk(0, 0, 0,  32'h0,        0, 1, 4,  32'h0000_5007, 0, 6'h00, 32'h0000_7F0D, 14, 32'h0000_5004, 1, 1, 6'h3F, 32'h0000_5004);
      vecs[19] = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        8,  bv_b,          1, 1, 6'h3F, 32'h0000_5004);
      vecs[20] = mk(0, 0, 0,  32'h0,        0, 1, 12, 32'h0000_6000, 0, 6'h00, 32'hFFFF_0000, 8,  bv_b,          1, 1, 6'h3F, 32'h0000_6000);
      vecs[21] = mk(1, 1, 12, 32'h0000_FC03, 0, 1, 12, 32'h0000_7000, 0, 6'h3F, 32'h0,        13, 32'h0,         0, 0, 6'h00, 32'h0);
      vecs[22] = mk(0, 0, 0,  32'h0,        0, 0, 0,  32'h0,        0, 6'h00, 32'h0,        14, 32'h0,         0, 0, 6'h00, 32'h0);

      {reset, WE, EXLClr, Exception, BD} = '0;
      A1 = '0; A2 = '0; DIn = '0; ExcCode = '0; PC = '0; HWInt = '0; BadAddr = '0;

      for (int i = 0; i < NV; i++) begin
         @(negedge clk);
         reset = vecs[i].rst; WE = vecs[i].we; A2 = vecs[i].a2; DIn = vecs[i].din;
         EXLClr = vecs[i].clr; Exception = vecs[i].exc; ExcCode = vecs[i].code;
         PC = vecs[i].pc; BD = vecs[i].bd; HWInt = vecs[i].hw; BadAddr = vecs[i].bad;
         A1 = vecs[i].rd;
         @(posedge clk);
         #1;
         check($sformatf("v%0d dout", i), DOut, vecs[i].e_dout);
         check($sformatf("v%0d exl", i), {31'd0, exl}, {31'd0, vecs[i].e_exl});
         check($sformatf("v%0d ie", i), {31'd0, ie}, {31'd0, vecs[i].e_ie});
         check($sformatf("v%0d im", i), {26'd0, im}, {26'd0, vecs[i].e_im});
         check($sformatf("v%0d epc", i), EPC, vecs[i].e_epc);
      end

      // No write-to-read bypass: DOut shows the old SR until the edge commits the write.
      @(negedge clk);
      {reset, EXLClr, Exception, BD} = '0;
      HWInt = '0;
      WE = 1'b1; A2 = 5'd12; DIn = 32'h0000_0403; A1 = 5'd12;
      #1;
      check("nobypass pre-edge", DOut, 32'h0);
      @(posedge clk);
      #1;
      check("nobypass post-edge", DOut, 32'h0000_0403);

      // EPC write ignores the low two data bits; exl written by SR write without eret.
      @(negedge clk);
      WE = 1'b1; A2 = 5'd14; DIn = 32'h0000_ABC7; A1 = 5'd14;
      @(posedge clk);
      #1;
      check("epc write align", DOut, 32'h0000_ABC4);
      check("exl set by mtc0", {31'd0, exl}, 32'd1);

      @(negedge clk);
      WE = 1'b0;
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/cp0_unit.md
CP0_UNIT -- requirements
Module: cp0_unit

Interface
REQ-001 SHALL have port clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port reset  input  1  synchronous active-high reset, sampled on clk rising edge.
REQ-003 SHALL have port A1  input  5  mfc0 read register number.
REQ-004 SHALL have port A2  input  5  mtc0 write register number.
REQ-005 SHALL have port DIn  input  32  mtc0 write data.
REQ-006 SHALL have port WE  input  1  mtc0 write enable, from M stage.
REQ-007 SHALL have port EXLClr  input  1  eret in M stage; clears SR.EXL.
REQ-008 SHALL have port Exception  input  1  exception commit strobe, already gated by ~exl, from the M-stage exception detector.
REQ-009 SHALL have port ExcCode  input  5  exception code (0 Int, 4 AdEL, 5 AdES, 10 RI, 12 Ov).
REQ-010 SHALL have port PC  input  32  PC of the M-stage instruction.
REQ-011 SHALL have port BD  input  1  M-stage instruction is in a branch delay slot.
REQ-012 SHALL have port HWInt  input  6  external interrupt lines.
REQ-013 SHALL have port BadAddr  input  32  M-stage data address (ALU result).
REQ-014 SHALL have port DOut  output  32  mfc0 read data, combinational from A1.
REQ-015 SHALL have port EPC  output  32  current EPC, used by eret.
REQ-016 SHALL have ports exl, ie  output  1 each, and im  output  6: SR fields fed back to the exception detector.

Function
REQ-017 SHALL implement SR (reg 12): im=bits[15:10], exl=bit1, ie=bit0; all other bits read 0.
REQ-018 SHALL implement Cause (reg 13): BD=bit31, IP=bits[15:10], ExcCode=bits[6:2]; all other bits read 0; mtc0 to Cause is ignored.
REQ-019 SHALL implement EPC (reg 14), 32 bits, with bits[1:0] forced to 0 on every update.
REQ-020 SHALL implement PRId (reg 15) as read-only constant 32'h2017_1226.
REQ-021 SHALL return 0 on DOut for any unimplemented A1; writes to unimplemented or read-only numbers have no effect.
REQ-022 SHALL sample Cause.IP <= HWInt on every clock edge, so IP has one-cycle latency.
REQ-023 On an Exception edge: exl<=1, Cause.ExcCode<=ExcCode, Cause.BD<=BD, EPC<=(BD ? PC-4 : PC) with bits[1:0] cleared.
REQ-024 Priority per edge SHALL be reset > Exception > WE > EXLClr; when Exception=1, a simultaneous mtc0 and eret are both discarded.
REQ-025 WE with A2=12 SHALL load im, exl, ie from DIn[15:10], DIn[1], DIn[0]; WE with A2=14 SHALL load EPC from {DIn[31:2],2'b00}.
REQ-026 EXLClr SHALL clear exl on the edge; when WE to SR coincides with EXLClr, the written SR value SHALL be stored and exl cleared afterward, i.e. exl<=0.
REQ-027 DOut SHALL reflect pre-edge register values; there is no internal write-to-read bypass (hazard logic stalls mfc0 after mtc0).
REQ-028 The EPC output SHALL equal the stored EPC register.

Reset
REQ-029 On reset, SR, Cause, EPC and BadVAddr SHALL be set to 0, giving outputs exl=0, ie=0, im=0, EPC=0, DOut=0 for any A1 other than 15.
REQ-030 Reset SHALL override a simultaneous Exception, WE or EXLClr, and no exception state survives a mid-handler reset.

Configuration
REQ-031 Macro CP0_BADVADDR_EN: when defined, SR SHALL implement reg 8 BadVAddr, read-only, loaded with BadAddr on an Exception edge whose ExcCode is 4 or 5, and otherwise held.
REQ-032 Without CP0_BADVADDR_EN, reg 8 SHALL read 0, the BadAddr port SHALL still exist and be ignored, and no register SHALL be inferred.

Verification
REQ-033 After reset: mtc0 SR with DIn=32'h0000_0C01, then read A1=12 -> DOut=32'h0000_0C01, im=6'b000011, ie=1, exl=0.
REQ-034 Exception=1, ExcCode=12, PC=32'h0000_3010, BD=0 -> next cycle exl=1, Cause[6:2]=12, EPC=32'h0000_3010.
REQ-035 Exception=1, BD=1, PC=32'h0000_3024 -> EPC=32'h0000_3020 and Cause bit31=1.
REQ-036 Exception, WE (A2=14, DIn=32'hFFFF_FFFF) and EXLClr in the same cycle -> EPC=PC of the excepting instruction and exl=1.
REQ-037 HWInt=6'b000010 held for one cycle -> Cause[15:10]=6'b000010 one cycle later and 0 the following cycle.
REQ-038 With CP0_BADVADDR_EN defined, Exception with ExcCode=4 and BadAddr=32'h0000_7F0D -> reg 8 reads 32'h0000_7F0D; an Exception with ExcCode=12 leaves reg 8 unchanged.
